// File: rtl/adex_loader_pkg.sv
// Shared constants and tx FSM encoding for the ADEX parameter-load protocol.
package adex_loader_pkg;

  localparam int unsigned NUM_PARAM_BYTES = 8;
  localparam int unsigned NUM_TOKENS      = 18;
  localparam logic [4:0]  LAST_TOKEN      = 5'(NUM_TOKENS - 1);
  localparam logic [3:0]  HEADER_NIB      = 4'h0;
  localparam logic [3:0]  FOOTER_NIB      = 4'hF;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_HIGH,
    TX_TAIL
  } tx_state_e;

endpackage

// File: rtl/adex_param_nibble_tx.sv
// Host-side ADEX parameter-load transmitter: header strobe, 16 data nibbles,
// footer strobe, then a load_mode tail so the receiver applies the parameters.
module adex_param_nibble_tx #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned HIGH_CYC   = 2,
  parameter int unsigned TAIL_CYC   = 4,
  parameter logic [3:0]  FOOTER_NIB = adex_loader_pkg::FOOTER_NIB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] params_in,
  input  logic        abort,
  output logic        load_mode,
  output logic        load_enable,
  output logic [3:0]  nib_out,
  output logic        busy,
  output logic        done,
  output logic        aborted
);
  import adex_loader_pkg::*;

  localparam int unsigned MAX_AB  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > TAIL_CYC) ? MAX_AB : TAIL_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  tx_state_e                          state, state_nxt;
  logic [CW-1:0]                      cnt, cnt_nxt;
  logic [4:0]                         tok, tok_nxt;
  logic [8*NUM_PARAM_BYTES-1:0]       snap, snap_nxt;
  logic [8*NUM_PARAM_BYTES-1:0]       snap_sh;
  logic [3:0]                         data_nib;
  logic                               lm_nxt, le_nxt, busy_nxt, done_nxt, ab_nxt;
  logic [3:0]                         nib_nxt;

  // State, counters, snapshot and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= TX_IDLE;
      cnt         <= '0;
      tok         <= '0;
      snap        <= '0;
      load_mode   <= 1'b0;
      load_enable <= 1'b0;
      nib_out     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tok         <= tok_nxt;
      snap        <= snap_nxt;
      load_mode   <= lm_nxt;
      load_enable <= le_nxt;
      nib_out     <= nib_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      aborted     <= ab_nxt;
    end
  end

  // Next-state and next-output logic; outputs describe the cycle being entered.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tok_nxt   = tok;
    snap_nxt  = snap;
    lm_nxt    = load_mode;
    le_nxt    = load_enable;
    nib_nxt   = nib_out;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    ab_nxt    = 1'b0;

    // Data token k (1..16) carries nibble k-1 of the snapshot, so the token
    // about to be entered from token tok is simply nibble index tok.
    snap_sh  = snap >> {tok[3:0], 2'b00};
    data_nib = snap_sh[3:0];

    case (state)
      TX_IDLE: begin
        cnt_nxt  = '0;
        tok_nxt  = '0;
        lm_nxt   = 1'b0;
        le_nxt   = 1'b0;
        nib_nxt  = '0;
        busy_nxt = 1'b0;
        if (start && !abort) begin
          snap_nxt  = params_in;
          state_nxt = TX_SETUP;
          lm_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          nib_nxt   = HEADER_NIB;
        end
      end
      TX_SETUP: begin
        if (cnt == CW'(SETUP_CYC - 1)) begin
          state_nxt = TX_HIGH;
          cnt_nxt   = '0;
          le_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TX_HIGH: begin
        if (cnt == CW'(HIGH_CYC - 1)) begin
          cnt_nxt = '0;
          le_nxt  = 1'b0;
          if (tok == LAST_TOKEN) begin
            state_nxt = TX_TAIL;
            nib_nxt   = FOOTER_NIB;
          end else begin
            state_nxt = TX_SETUP;
            tok_nxt   = tok + 5'd1;
            nib_nxt   = (tok == LAST_TOKEN - 5'd1) ? FOOTER_NIB : data_nib;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TX_TAIL: begin
        if (cnt == CW'(TAIL_CYC - 1)) begin
          state_nxt = TX_IDLE;
          cnt_nxt   = '0;
          tok_nxt   = '0;
          lm_nxt    = 1'b0;
          nib_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase

    // Cancellation overrides whatever the active state decided this cycle.
    if (state != TX_IDLE && abort) begin
      state_nxt = TX_IDLE;
      cnt_nxt   = '0;
      tok_nxt   = '0;
      lm_nxt    = 1'b0;
      le_nxt    = 1'b0;
      nib_nxt   = '0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      ab_nxt    = 1'b1;
    end
  end

endmodule
